// File: rtl/sha3_pkg.sv
// Shared SHA3 types and helpers: state layout, variant IDs, digest length and lane byte swap.
package sha3_pkg;

  typedef logic [0:4][0:4][63:0] sha3_state_t;

  typedef enum logic [1:0] {
    SHA3_224 = 2'd0,
    SHA3_256 = 2'd1,
    SHA3_384 = 2'd2,
    SHA3_512 = 2'd3
  } sha3_id_t;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

  // Digest length in 16-bit words.
  function automatic logic [5:0] digest_words(input sha3_id_t id);
    case (id)
      SHA3_224: digest_words = 6'd14;
      SHA3_256: digest_words = 6'd16;
      SHA3_384: digest_words = 6'd24;
      default:  digest_words = 6'd32;
    endcase
  endfunction

  // Keccak lanes are little-endian; the digest wants the lane's first byte on top.
  function automatic logic [63:0] revers_byte(input logic [63:0] v);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = v[8*(7-i) +: 8];
    return r;
  endfunction

endpackage

// File: rtl/sha3_digest_tx_if.sv
// Digest output stream: valid/ready with TLAST, driven by the master.
interface sha3_digest_tx_if #(
  parameter int WIDTH = 16
) ();
  logic [WIDTH-1:0] M_TDATA;
  logic             M_TVALID;
  logic             M_TREADY;
  logic             M_TLAST;

  modport master (output M_TDATA, output M_TVALID, output M_TLAST, input  M_TREADY);
  modport slave  (input  M_TDATA, input  M_TVALID, input  M_TLAST, output M_TREADY);
endinterface

// File: rtl/sha3_digest_tx.sv
// Captures the final Keccak state and streams the truncated digest 16 bits at a time,
// first digest byte in the upper half of each word.
module sha3_digest_tx
  import sha3_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int LANE_W = 64
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  sha3_state_t       state_in,
  input  logic [1:0]        ID,
  input  logic              state_valid,
  output logic              state_ready,
  output logic              busy,
  sha3_digest_tx_if.master  m
);

  localparam int BUF_W = 8 * LANE_W;

  tx_state_e        state_q;
  logic [5:0]       cnt_q;
  logic [BUF_W-1:0] buf_q;
  logic [BUF_W-1:0] lanes_d;

  // Lane i sits at (x,y) = (i%5, i/5); lane 0 lands in the top of the buffer.
  always_comb begin
    lanes_d = '0;
    for (int i = 0; i < 8; i++)
      lanes_d[BUF_W-1-LANE_W*i -: LANE_W] = revers_byte(state_in[i%5][i/5]);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      case (state_q)
        TX_IDLE: begin
          if (state_valid) begin
            buf_q   <= lanes_d;
            cnt_q   <= digest_words(sha3_id_t'(ID));
            state_q <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (m.M_TREADY) begin
            buf_q <= buf_q << WIDTH;
            cnt_q <= cnt_q - 6'd1;
            if (cnt_q == 6'd1) state_q <= TX_IDLE;
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  assign m.M_TVALID  = (state_q == TX_SEND);
  assign m.M_TLAST   = (state_q == TX_SEND) && (cnt_q == 6'd1);
  assign m.M_TDATA   = buf_q[BUF_W-1 -: WIDTH];
  assign busy        = (state_q == TX_SEND);
  assign state_ready = (state_q == TX_IDLE);

  // Only lanes 0-7 carry digest bytes; the rest of the state is intentionally dropped.
  logic unused_state;
  assign unused_state = ^state_in;

endmodule

// File: doc/sha3_digest_tx.md
Name: sha3_digest_tx

Overview:
- Transmit side of the SHA3 core's stream interface. Takes the final 1600-bit Keccak state and the SHA3 variant ID after absorption completes.
- Serialises the truncated digest onto a 16-bit valid/ready stream with TLAST, in standard digest byte order.
- Sits between the permutation core's Dout/Last outputs and the downstream AXI-Stream sink (DMA or UART bridge).

Parameters:
- WIDTH, 16, output word width in bits; only 16 is supported, and the digest lengths are multiples of it.
- LANE_W, 64, Keccak lane width in bits; fixed.

Ports:
- ACLK  in  1  clock, all logic on rising edge.
- ARESET  in  1  synchronous, active-high reset.
- state_in  in  [0:4][0:4][63:0]  final Keccak state, in the same layout as the core's Dout.
- ID  in  2  variant: 0 SHA3-224, 1 SHA3-256, 2 SHA3-384, 3 SHA3-512; sampled with state_in.
- state_valid  in  1  state_in/ID valid; the core drives this from its Last strobe.
- state_ready  out  1  block can accept a new state.
- M_TDATA  out  WIDTH  digest word.
- M_TVALID  out  1  word valid.
- M_TREADY  in  1  sink ready.
- M_TLAST  out  1  final word of digest.
- busy  out  1  transfer in progress.

Behaviour:
- Reset values: M_TVALID=0, M_TLAST=0, M_TDATA=0, busy=0, state_ready=1, word counter=0, buffer=0. FSM goes to IDLE.
- Reset applies on any edge with ARESET=1, including mid-transfer. The partial digest is discarded and no TLAST is emitted.
- FSM has two states, IDLE and SEND.
- IDLE:
  - state_ready=1 (combinational from state).
  - On state_valid=1, capture the 8 lanes in order (0,0),(1,0),(2,0),(3,0),(4,0),(0,1),(1,1),(2,1) into a 512-bit buffer.
  - Each lane is byte-reversed, so the lane's least-significant byte becomes the buffer's most-significant byte of that lane.
  - Latch the word count from ID: 14, 16, 24 or 32. Go to SEND.
- SEND:
  - M_TVALID=1, busy=1, state_ready=0.
  - M_TDATA = buffer[511:496]. The first digest byte is on [15:8], the second on [7:0].
  - On handshake (M_TVALID & M_TREADY): shift the buffer left by 16, decrement the counter.
  - M_TLAST=1 exactly when the counter equals 1.
  - On the handshake of the TLAST word, go to IDLE and deassert M_TVALID/M_TLAST in the same edge.
- Latency: first word is valid on the cycle after the state_valid capture edge.
- Throughput: one word per cycle under M_TREADY=1. There is one IDLE cycle between consecutive digests.
- Backpressure: while M_TVALID=1 and M_TREADY=0, M_TDATA and M_TLAST hold stable. M_TVALID never drops before its handshake (AXI-Stream rule).
- state_valid during SEND is ignored (state_ready=0). The core holds Last/Dout until accepted.
- SHA3-224 truncation: 28 bytes = lanes 0-2 plus the upper 4 buffered bytes of lane 3. Remaining buffer content is never emitted.
- Only lanes 0-7 are used; the other 17 lanes of state_in are don't-care.

Decomposition:
- Shared package sha3_pkg:
  - typedef sha3_state_t = logic [0:4][0:4][63:0].
  - enum sha3_id_t (SHA3_224=0, SHA3_256, SHA3_384, SHA3_512).
  - function digest_words(sha3_id_t), returning 14/16/24/32.
  - function revers_byte(logic [63:0]), the 64-bit byte swap used by benches and RTL alike.
- No sub-module is warranted. It is a single FSM plus a shift buffer; byte reversal comes from the package function.

Test Plan:
- Empty-message SHA3-224 state, ID=0, M_TREADY=1:
  - exactly 14 words;
  - word0=16'h6b4e, word1=16'h0342, word13=16'h6bc7;
  - M_TLAST only on word 13;
  - concatenation = 6b4e03423667dbb73b6e15454f0eb1abd4597f9a1b078e3f5b5a6bc7.
- Empty-message SHA3-256 state, ID=1:
  - 16 words;
  - word0=16'ha7ff, word15=16'h434a;
  - full stream equals a7ffc6f8...80f8434a.
- SHA3-512 with M_TREADY toggled randomly (50%):
  - 32 words, with TDATA/TLAST stable across every stalled cycle;
  - word0=16'ha69f for the empty message.
- Back-to-back: ID=3 then ID=0 states presented with state_valid held high:
  - second capture occurs one cycle after the first TLAST handshake;
  - streams are 32 words then 14 words, with no word lost or duplicated.
- ARESET pulsed after word 5 of a SHA3-256 transfer:
  - next edge gives M_TVALID=0, M_TLAST=0, state_ready=1;
  - a new state then streams from word0.
- state_valid pulsed during SEND:
  - ignored, with the current digest unaffected;
  - a scoreboard confirms exactly one TLAST per accepted state.
